// File: rtl/swire_sched_if.sv
// Request/acknowledge bundle between the two DCS-decoded S-Wire requesters
// (B1 panel voltage, B5 backlight/ELVDD) and the S-Wire scheduler.
// Signal names carry the scheduler's point of view (i_ into it, o_ out of it).
interface swire_sched_if;
  logic        i_b1_req;
  logic [15:0] i_b1_data;
  logic        o_b1_ack;
  logic        i_b5_req;
  logic [15:0] i_b5_data;
  logic        o_b5_ack;

  // Requester side: raises req with {addr_cnt, val_cnt}, waits for ack
  modport master (
    output i_b1_req, i_b1_data, i_b5_req, i_b5_data,
    input  o_b1_ack, o_b5_ack
  );

  // Scheduler side
  modport slave (
    input  i_b1_req, i_b1_data, i_b5_req, i_b5_data,
    output o_b1_ack, o_b5_ack
  );
endinterface

// File: rtl/swire_sched.sv
// S-Wire scheduler: waits out the power-up start delay, then round-robin
// arbitrates B1/B5 requests and plays each one out as an address pulse burst
// followed by a value pulse burst, each non-empty burst followed by a latch gap.
module swire_sched #(
  parameter int START_DLY = 24'hfffff0,
  parameter int T_LOW     = 38,
  parameter int T_HIGH    = 38,
  parameter int T_GAP     = 760
) (
  input  logic             i_clk_38m,
  input  logic             i_reset,
  swire_sched_if.slave     i_req_bus,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_swire
);

  localparam int DATA_W = 16;
  localparam int T_LH   = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
  localparam int T_MAX  = (T_LH > T_GAP) ? T_LH : T_GAP;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [23:0]      START_LAST = 24'(START_DLY - 1);
  localparam logic [TMR_W-1:0] LOW_LD     = TMR_W'(T_LOW - 1);
  localparam logic [TMR_W-1:0] HIGH_LD    = TMR_W'(T_HIGH - 1);
  localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_WAIT_START, S_IDLE, S_A_LOW, S_A_HIGH, S_A_GAP, S_V_LOW, S_V_HIGH, S_V_GAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [23:0]         r_start_cnt;
  logic [TMR_W-1:0]    r_tmr;
  logic [7:0]          r_pcnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_last_b5;
  logic                r_b1_ack;
  logic                r_b5_ack;
  logic                r_ready;
  logic                r_busy;
  logic                r_swire;
  logic                w_tmr_done;
  logic                w_can_grant;
  logic                w_grant_b1;
  logic                w_grant_b5;
  logic                w_ready_nxt;
  logic                w_busy_nxt;
  logic                w_swire_nxt;

  // Reload value of the phase timer on entry to a timed state
  function automatic logic [TMR_W-1:0] phase_len(input state_t s);
    case (s)
      S_A_LOW, S_V_LOW:   phase_len = LOW_LD;
      S_A_HIGH, S_V_HIGH: phase_len = HIGH_LD;
      S_A_GAP, S_V_GAP:   phase_len = GAP_LD;
      default:            phase_len = '0;
    endcase
  endfunction

  assign w_tmr_done = (r_tmr == '0);

  // Next-state: the cycle after an ack starts the first non-empty burst
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_START: if (r_start_cnt == START_LAST) w_next = S_IDLE;
      S_IDLE: begin
        if (r_b1_ack || r_b5_ack) begin
          if (r_data[15:8] != 8'd0)     w_next = S_A_LOW;
          else if (r_data[7:0] != 8'd0) w_next = S_V_LOW;
        end
      end
      S_A_LOW:  if (w_tmr_done) w_next = S_A_HIGH;
      S_A_HIGH: if (w_tmr_done) w_next = (r_pcnt == 8'd1) ? S_A_GAP : S_A_LOW;
      S_A_GAP:  if (w_tmr_done) w_next = (r_data[7:0] != 8'd0) ? S_V_LOW : S_IDLE;
      S_V_LOW:  if (w_tmr_done) w_next = S_V_HIGH;
      S_V_HIGH: if (w_tmr_done) w_next = (r_pcnt == 8'd1) ? S_V_GAP : S_V_LOW;
      S_V_GAP:  if (w_tmr_done) w_next = S_IDLE;
      default:  w_next = S_WAIT_START;
    endcase
  end

  // Outputs are computed one state ahead so they can be registered; a grant
  // is decided on the edge entering (or staying in) IDLE, never right after an ack
  always_comb begin
    w_can_grant = (w_next == S_IDLE) && !r_b1_ack && !r_b5_ack;
    w_grant_b5  = w_can_grant && i_req_bus.i_b5_req &&
                  (!i_req_bus.i_b1_req || !r_last_b5);
    w_grant_b1  = w_can_grant && i_req_bus.i_b1_req && !w_grant_b5;
    w_ready_nxt = (w_next != S_WAIT_START);
    w_busy_nxt  = w_ready_nxt && (w_next != S_IDLE);
    w_swire_nxt = w_ready_nxt && (w_next != S_A_LOW) && (w_next != S_V_LOW);
  end

  // State, timers, arbitration pointer and registered outputs
  always_ff @(posedge i_clk_38m) begin
    if (i_reset) begin
      r_state     <= S_WAIT_START;
      r_start_cnt <= '0;
      r_tmr       <= '0;
      r_pcnt      <= '0;
      r_last_b5   <= 1'b0;
      r_b1_ack    <= 1'b0;
      r_b5_ack    <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_swire     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT_START) r_start_cnt <= r_start_cnt + 24'd1;
      if (w_next != r_state)       r_tmr <= phase_len(w_next);
      else if (!w_tmr_done)        r_tmr <= r_tmr - TMR_W'(1);
      if (r_state == S_IDLE && w_next == S_A_LOW)
        r_pcnt <= r_data[15:8];
      else if (w_next == S_V_LOW && (r_state == S_IDLE || r_state == S_A_GAP))
        r_pcnt <= r_data[7:0];
      else if ((r_state == S_A_HIGH || r_state == S_V_HIGH) && w_tmr_done)
        r_pcnt <= r_pcnt - 8'd1;
      if (w_grant_b1 || w_grant_b5) r_last_b5 <= w_grant_b5;
      r_b1_ack <= w_grant_b1;
      r_b5_ack <= w_grant_b5;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
      r_swire  <= w_swire_nxt;
    end
  end

  // Capture the granted requester's counts; payload register needs no reset
  always_ff @(posedge i_clk_38m) begin
    if (w_grant_b5)      r_data <= i_req_bus.i_b5_data;
    else if (w_grant_b1) r_data <= i_req_bus.i_b1_data;
  end

  assign i_req_bus.o_b1_ack = r_b1_ack;
  assign i_req_bus.o_b5_ack = r_b5_ack;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_swire = r_swire;

endmodule
